seg7_scroll_driver: RTL

// - Time-multiplexed driver for an N-digit seven-segment display showing a scrolling message.
// - Holds a writable MSG_LEN-glyph buffer; scans one digit per refresh tick.
// - Scrolls the visible window left or right every SCROLL_FRAMES complete scan frames.
// - Sits between user logic (writes glyph codes) and the board's display pins.

---
 rtl/seg7_scroll_driver.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scroll_driver.sv
// seg7_scroll_driver
//   Time-multiplexed driver for an N-digit seven-segment display that shows a
//   window of a writable glyph buffer and scrolls that window every
//   SCROLL_FRAMES complete scan frames.
//
// Ports
//   clk           in   clock
//   nrst          in   asynchronous active-low reset
//   wr_en_i       in   write wr_data_i into buffer[wr_addr_i] this cycle
//   wr_addr_i     in   buffer address; addresses >= MSG_LEN are ignored
//   wr_data_i     in   5-bit glyph code
//   scroll_en_i   in   1: window steps at every SCROLL_FRAMES-th frame end
//   scroll_dir_i  in   0: offset+1 (text moves left); 1: offset-1
//   blink_mask_i  in   (BLINK_EN only) bit k blanks digit index k during blink phase
//   offset_o      out  current window start index
//   frame_tick_o  out  one-cycle pulse, coincident with the digit-0 anode
//   cathodes_o    out  {a,b,c,d,e,f,g,dp} pin levels
//   anodes_o      out  one-hot digit select pin levels, MSB = leftmost digit
//
// Build option
//   BLINK_EN  adds blink_mask_i and a blink phase toggling every 32 frame ends.

module seg7_scroll_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int MSG_LEN       = 16,
    parameter int REFRESH_DIV   = 50000,
    parameter int SCROLL_FRAMES = 100,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       wr_en_i,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr_i,
    input  logic [4:0]                 wr_data_i,
    input  logic                       scroll_en_i,
    input  logic                       scroll_dir_i,
`ifdef BLINK_EN
    input  logic [NUM_DIGITS-1:0]      blink_mask_i,
`endif
    output logic [$clog2(MSG_LEN)-1:0] offset_o,
    output logic                       frame_tick_o,
    output logic [7:0]                 cathodes_o,
    output logic [NUM_DIGITS-1:0]      anodes_o
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    // XOR masks turning logical levels into pin levels (also the idle pin levels)
    localparam logic [7:0]            CATH_OFF = {8{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW != 0}};

    localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]  DIG_LAST   = DW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]  FRM_LAST   = FW'(SCROLL_FRAMES - 1);
    localparam logic [AW-1:0]  OFF_LAST   = AW'(MSG_LEN - 1);
    localparam logic [AW:0]    LEN_W      = (AW + 1)'(MSG_LEN);

    if (MSG_LEN < NUM_DIGITS) begin : g_bad_len
        $error("seg7_scroll_driver: MSG_LEN must be >= NUM_DIGITS");
    end
    if (NUM_DIGITS < 2 || REFRESH_DIV < 2 || SCROLL_FRAMES < 1) begin : g_bad_param
        $error("seg7_scroll_driver: parameter out of range");
    end

    logic [4:0]            buf_q [MSG_LEN];
    logic [PW-1:0]         presc_q, presc_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [FW-1:0]         frm_q, frm_d;
    logic [AW-1:0]         offset_q, offset_d;
    logic                  last_q, last_d;
    logic                  ftick_q, ftick_d;
    logic [7:0]            cath_q, cath_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  slot_tick;
    logic                  frame_end;
    logic [AW:0]           idx_sum;
    logic [AW-1:0]         rd_idx;
    logic [4:0]            glyph;
    logic [7:0]            seg;
    logic [NUM_DIGITS-1:0] an_hot;
    logic                  seg_blank;

    // dig_q is the digit loaded at the next slot tick. last_q marks that the
    // rightmost digit is lit, so the tick that ends its slot is the frame end.
    assign slot_tick = (presc_q == PRESC_LAST);
    assign frame_end = slot_tick && last_q;

    always_comb begin
        presc_d = slot_tick ? '0 : presc_q + PW'(1);
        dig_d   = dig_q;
        last_d  = last_q;
        if (slot_tick) begin
            dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
            last_d = (dig_q == DIG_LAST);
        end
        ftick_d = frame_end;
    end

    always_comb begin
        frm_d    = frm_q;
        offset_d = offset_q;
        if (frame_end) begin
            if (frm_q == FRM_LAST) begin
                frm_d = '0;
                if (scroll_en_i) begin
                    if (!scroll_dir_i) begin
                        offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + AW'(1);
                    end else begin
                        offset_d = (offset_q == '0) ? OFF_LAST : offset_q - AW'(1);
                    end
                end
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end
    end

    // The frame-end tick also loads digit 0 of the new frame, so the read uses
    // offset_d: every digit of a frame sees the same offset.
    always_comb begin
        idx_sum = (AW + 1)'(offset_d) + (AW + 1)'(dig_q);
        rd_idx  = (idx_sum >= LEN_W) ? AW'(idx_sum - LEN_W) : AW'(idx_sum);
        glyph   = buf_q[rd_idx];
    end

    always_comb begin
        case (glyph)
            5'h00:   seg = 8'hFC;
            5'h01:   seg = 8'h60;
            5'h02:   seg = 8'hDA;
            5'h03:   seg = 8'hF2;
            5'h04:   seg = 8'h66;
            5'h05:   seg = 8'hB6;
            5'h06:   seg = 8'hBE;
            5'h07:   seg = 8'hE0;
            5'h08:   seg = 8'hFE;
            5'h09:   seg = 8'hF6;
            5'h0A:   seg = 8'hEE;
            5'h0B:   seg = 8'h3E;
            5'h0C:   seg = 8'h9C;
            5'h0D:   seg = 8'h7A;
            5'h0E:   seg = 8'h9E;
            5'h0F:   seg = 8'h8E;
            5'h10:   seg = 8'h6E;
            5'h11:   seg = 8'h1C;
            5'h12:   seg = 8'hCE;
            5'h13:   seg = 8'h7C;
            5'h14:   seg = 8'h02;
            5'h15:   seg = 8'h3A;
            5'h16:   seg = 8'h2A;
            default: seg = 8'h00;
        endcase
    end

    always_comb begin
        an_hot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_q == DW'(NUM_DIGITS - 1 - k)) an_hot[k] = 1'b1;
        end
    end

`ifdef BLINK_EN
    logic [4:0] blk_cnt_q, blk_cnt_d;
    logic       phase_q, phase_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (frame_end) begin
            blk_cnt_d = blk_cnt_q + 5'd1;
            if (blk_cnt_q == 5'd31) phase_d = ~phase_q;
        end
    end

    // phase_d so the toggle lines up with digit 0 of the new frame
    assign seg_blank = phase_d && blink_mask_i[dig_q];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end
`else
    assign seg_blank = 1'b0;
`endif

    always_comb begin
        cath_d = cath_q;
        an_d   = an_q;
        if (slot_tick) begin
            cath_d = (seg_blank ? 8'h00 : seg) ^ CATH_OFF;
            an_d   = an_hot ^ AN_OFF;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q  <= '0;
            dig_q    <= '0;
            frm_q    <= '0;
            offset_q <= '0;
            last_q   <= 1'b0;
            ftick_q  <= 1'b0;
            cath_q   <= CATH_OFF;
            an_q     <= AN_OFF;
        end else begin
            presc_q  <= presc_d;
            dig_q    <= dig_d;
            frm_q    <= frm_d;
            offset_q <= offset_d;
            last_q   <= last_d;
            ftick_q  <= ftick_d;
            cath_q   <= cath_d;
            an_q     <= an_d;
        end
    end

    // A same-cycle write lands after the read above, so the display gets the old glyph.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < MSG_LEN; k++) buf_q[k] <= 5'h1F;
        end else if (wr_en_i && ((AW + 1)'(wr_addr_i) < LEN_W)) begin
            buf_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign offset_o     = offset_q;
    assign frame_tick_o = ftick_q;
    assign cathodes_o   = cath_q;
    assign anodes_o     = an_q;

endmodule
